// File: rtl/gcd_cfu_pkg.sv
// -----------------------------------------------------------------------------
// gcd_cfu_pkg
//   Shared types for the pooled GCD CFU.
//   - Default CFU bus widths, used as parameter defaults by the top level.
//   - Engine state enum {IDLE, RUN, DONE}.
//   - Error codes carried from dispatch to resp_err_id.
// -----------------------------------------------------------------------------
package gcd_cfu_pkg;

    localparam int CFU_FUNC_ID_W_DEF     = 1;
    localparam int CFU_REQ_RESP_ID_W_DEF = 8;
    localparam int CFU_REQ_DATA_W_DEF    = 32;
    localparam int CFU_RESP_DATA_W_DEF   = 32;
    localparam int CFU_ERR_ID_W_DEF      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } eng_state_e;

    typedef enum logic [1:0] {
        GCD_ERR_NONE = 2'd0,
        GCD_ERR_FUNC = 2'd1,
        GCD_ERR_ZERO = 2'd2
    } gcd_err_e;

endpackage

// File: rtl/gcd_engine.sv
// -----------------------------------------------------------------------------
// gcd_engine
//   One subtract/swap GCD engine. Latches operands, tag and error code on
//   start, iterates one step per cycle, then holds its result until granted.
//
//   state | meaning
//   IDLE  | free, may be started by the dispatcher
//   RUN   | one step per cycle: swap if a<b, else a-=b, else finish with a
//   DONE  | result valid, waiting for an output grant
//
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   start         dispatcher selects this engine (only honoured in IDLE)
//   a_in, b_in    operands
//   id_in         request tag
//   err_in        gcd_err_e code computed at dispatch; nonzero skips RUN
//   grant         output arbiter has taken the result
//   idle, done    state flags
//   result        gcd (0 for error completions)
//   id_out        latched tag
//   err_out       latched error code
// -----------------------------------------------------------------------------
module gcd_engine
    import gcd_cfu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [ID_W-1:0]   id_in,
    input  logic [1:0]        err_in,
    input  logic              grant,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ID_W-1:0]   id_out,
    output logic [1:0]        err_out
);

    eng_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    gcd_err_e          err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            err_q   <= GCD_ERR_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    id_d  = id_in;
                    err_d = gcd_err_e'(err_in);
                    if (gcd_err_e'(err_in) != GCD_ERR_NONE) begin
                        // error completions report data 0 and never iterate
                        a_d     = '0;
                        b_d     = '0;
                        state_d = DONE;
                    end else begin
                        a_d     = a_in;
                        b_d     = b_in;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (a_q < b_q) begin
                    a_d = b_q;
                    b_d = a_q;
                end else if (b_q != '0) begin
                    a_d = a_q - b_q;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle    = (state_q == IDLE);
    assign done    = (state_q == DONE);
    assign result  = a_q;
    assign id_out  = id_q;
    assign err_out = err_q;

endmodule

// File: rtl/gcd_cfu_li3_pool.sv
// -----------------------------------------------------------------------------
// gcd_cfu_li3_pool
//   Level-3 CFU computing GCD with a pool of NUM_ENGINES engines. New requests
//   go to the lowest-index idle engine; finished engines are drained
//   round-robin through one response register, so responses can come back
//   out of order and are matched by resp_id.
//
// Build option
//   GCD_CFU_ZERO_ERR_EN  defined: a=b=0 completes as error (err_id 2, data 0)
//                        undefined: a=b=0 returns data 0, no error
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/ready     request handshake; ready = some engine idle (registered)
//   req_func_id         0 = GCD, anything else completes with err_id 1
//   req_id              tag echoed on resp_id
//   req_data0/1         operands a, b (unsigned)
//   resp_valid/ready    response handshake; outputs held while stalled
//   resp_id             tag of the answered request
//   resp_data           gcd(a,b), 0 on error
//   resp_err            error flag
//   resp_err_id         error code (0 none, 1 bad func_id, 2 zero operands)
// -----------------------------------------------------------------------------
module gcd_cfu_li3_pool
    import gcd_cfu_pkg::*;
#(
    parameter int CFU_FUNC_ID_W     = CFU_FUNC_ID_W_DEF,
    parameter int CFU_REQ_RESP_ID_W = CFU_REQ_RESP_ID_W_DEF,
    parameter int CFU_REQ_DATA_W    = CFU_REQ_DATA_W_DEF,
    parameter int CFU_RESP_DATA_W   = CFU_RESP_DATA_W_DEF,
    parameter int CFU_ERR_ID_W      = CFU_ERR_ID_W_DEF,
    parameter int NUM_ENGINES       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [CFU_FUNC_ID_W-1:0]     req_func_id,
    input  logic [CFU_REQ_RESP_ID_W-1:0] req_id,
    input  logic [CFU_REQ_DATA_W-1:0]    req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]    req_data1,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
    output logic [CFU_RESP_DATA_W-1:0]   resp_data,
    output logic                         resp_err,
    output logic [CFU_ERR_ID_W-1:0]      resp_err_id
);

    localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

`ifdef GCD_CFU_ZERO_ERR_EN
    localparam bit ZERO_ERR_EN = 1'b1;
`else
    localparam bit ZERO_ERR_EN = 1'b0;
`endif

    logic [NUM_ENGINES-1:0]       idle_vec;
    logic [NUM_ENGINES-1:0]       done_vec;
    logic [NUM_ENGINES-1:0]       start_vec;
    logic [NUM_ENGINES-1:0]       grant_vec;
    logic [CFU_REQ_DATA_W-1:0]    eng_result [NUM_ENGINES];
    logic [CFU_REQ_RESP_ID_W-1:0] eng_id     [NUM_ENGINES];
    logic [1:0]                   eng_err    [NUM_ENGINES];

    logic             accept;
    logic [1:0]       req_err_code;
    logic [IDX_W-1:0] disp_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] rr_cand;
    logic [IDX_W:0]   rr_sum;
    logic             any_done;
    logic             load;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng
        gcd_engine #(
            .DATA_W (CFU_REQ_DATA_W),
            .ID_W   (CFU_REQ_RESP_ID_W)
        ) u_eng (
            .clk     (clk),
            .rst     (rst),
            .start   (start_vec[g]),
            .a_in    (req_data0),
            .b_in    (req_data1),
            .id_in   (req_id),
            .err_in  (req_err_code),
            .grant   (grant_vec[g]),
            .idle    (idle_vec[g]),
            .done    (done_vec[g]),
            .result  (eng_result[g]),
            .id_out  (eng_id[g]),
            .err_out (eng_err[g])
        );
    end

    // req_ready depends only on engine state registers
    assign req_ready = |idle_vec;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err_code = GCD_ERR_NONE;
        if (req_func_id != '0) begin
            req_err_code = GCD_ERR_FUNC;
        end else if (ZERO_ERR_EN && (req_data0 == '0) && (req_data1 == '0)) begin
            req_err_code = GCD_ERR_ZERO;
        end
    end

    // lowest-index idle engine: scan downward so the smallest index wins
    always_comb begin
        disp_idx  = '0;
        start_vec = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (idle_vec[i]) disp_idx = IDX_W'(i);
        end
        for (int i = 0; i < NUM_ENGINES; i++) begin
            start_vec[i] = accept && (disp_idx == IDX_W'(i));
        end
    end

    // round-robin: smallest offset from rr_ptr wins, scanned downward
    always_comb begin
        win_idx  = '0;
        any_done = 1'b0;
        rr_sum   = '0;
        rr_cand  = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            rr_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (rr_sum >= (IDX_W + 1)'(NUM_ENGINES)) begin
                rr_sum = rr_sum - (IDX_W + 1)'(NUM_ENGINES);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (done_vec[rr_cand]) begin
                any_done = 1'b1;
                win_idx  = rr_cand;
            end
        end
    end

    assign load = !resp_valid || resp_ready;

    always_comb begin
        grant_vec = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            grant_vec[i] = load && any_done && (win_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            resp_err_id <= '0;
            rr_ptr      <= '0;
        end else if (load) begin
            if (any_done) begin
                resp_valid  <= 1'b1;
                resp_id     <= eng_id[win_idx];
                resp_data   <= eng_result[win_idx];
                resp_err    <= (eng_err[win_idx] != 2'd0);
                resp_err_id <= CFU_ERR_ID_W'(eng_err[win_idx]);
                rr_ptr      <= (win_idx == IDX_W'(NUM_ENGINES - 1)) ? '0
                                                                     : win_idx + IDX_W'(1);
            end else begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcd_cfu_li3_pool.sv
module tb_gcd_cfu_li3_pool;

    localparam int N = 4;

`ifdef GCD_CFU_ZERO_ERR_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [0:0]  req_func_id = '0;
    logic [7:0]  req_id = '0;
    logic [31:0] req_data0 = '0;
    logic [31:0] req_data1 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [7:0]  resp_id;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] resp_err_id;

    gcd_cfu_li3_pool #(.NUM_ENGINES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_func_id (req_func_id),
        .req_id      (req_id),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .resp_err_id (resp_err_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference: Euclid by remainder, independent of how the DUT iterates
    function automatic longint unsigned gcd_ref(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // outstanding requests keyed by tag
    longint unsigned exp_data [int];
    int              exp_err  [int];
    int              exp_eid  [int];
    int              acc_at   [int];
    int              inflight = 0;

    typedef struct {
        int              id;
        longint unsigned data;
        int              err;
        int              eid;
        int              cyc;
        int              lat;
    } rsp_t;
    rsp_t got_q[$];

    logic        p_hold = 1'b0;
    logic [7:0]  p_id;
    logic [31:0] p_data;
    logic        p_err;
    logic [31:0] p_eid;

    // single compare process; handshakes seen here complete at the next posedge
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
            exp_data.delete();
            exp_err.delete();
            exp_eid.delete();
            acc_at.delete();
            inflight = 0;
            p_hold   = 1'b0;
        end else begin
            // engines busy = requests accepted but not yet moved into the response register
            chk("req_ready_occupancy", {63'd0, req_ready},
                {63'd0, ((inflight - int'(resp_valid)) < N)});
            if (p_hold) begin
                chk("hold_valid", {63'd0, resp_valid}, 64'd1);
                chk("hold_id", {56'd0, resp_id}, {56'd0, p_id});
                chk("hold_data", {32'd0, resp_data}, {32'd0, p_data});
                chk("hold_err", {63'd0, resp_err}, {63'd0, p_err});
                chk("hold_err_id", {32'd0, resp_err_id}, {32'd0, p_eid});
            end
            if (resp_valid && resp_ready) begin
                n_chk++;
                if (!exp_data.exists(int'(resp_id))) begin
                    n_fail++;
                    $display("FAIL resp_id_known actual=%0d required=an outstanding tag", resp_id);
                end else begin
                    rsp_t r;
                    chk("resp_data", {32'd0, resp_data}, exp_data[int'(resp_id)]);
                    chk("resp_err", {63'd0, resp_err}, 64'(exp_err[int'(resp_id)]));
                    chk("resp_err_id", {32'd0, resp_err_id}, 64'(exp_eid[int'(resp_id)]));
                    r.id   = int'(resp_id);
                    r.data = resp_data;
                    r.err  = int'(resp_err);
                    r.eid  = int'(resp_err_id);
                    r.cyc  = cyc;
                    r.lat  = cyc - acc_at[int'(resp_id)] - 1;
                    got_q.push_back(r);
                    exp_data.delete(int'(resp_id));
                    exp_err.delete(int'(resp_id));
                    exp_eid.delete(int'(resp_id));
                    acc_at.delete(int'(resp_id));
                    inflight--;
                end
            end
            if (req_valid && req_ready) begin
                int k;
                k = int'(req_id);
                if (req_func_id != 0) begin
                    exp_data[k] = 0; exp_err[k] = 1; exp_eid[k] = 1;
                end else if (ZEN && req_data0 == 0 && req_data1 == 0) begin
                    exp_data[k] = 0; exp_err[k] = 1; exp_eid[k] = 2;
                end else begin
                    exp_data[k] = gcd_ref(longint'(req_data0), longint'(req_data1));
                    exp_err[k]  = 0;
                    exp_eid[k]  = 0;
                end
                acc_at[k] = cyc;
                inflight++;
            end
            p_hold = resp_valid && !resp_ready;
            p_id   = resp_id;
            p_data = resp_data;
            p_err  = resp_err;
            p_eid  = resp_err_id;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int id, input longint unsigned a, input longint unsigned b, input int f);
        req_valid   = 1'b1;
        req_id      = 8'(id);
        req_data0   = 32'(a);
        req_data1   = 32'(b);
        req_func_id = 1'(f);
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (req_ready) break;
            if (k > 3000) begin
                chk("send_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (got_q.size() >= n) break;
            @(negedge clk);
        end
        chk("resp_count", 64'(got_q.size()), 64'(n));
        sync();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    bit rand_done = 1'b0;
    int next_id   = 0;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_id", {56'd0, resp_id}, 64'd0);
        chk("reset_resp_data", {32'd0, resp_data}, 64'd0);
        chk("reset_resp_err", {63'd0, resp_err}, 64'd0);
        chk("reset_resp_err_id", {32'd0, resp_err_id}, 64'd0);
        sync();
        rst = 1'b1;
        sync();

        // single request (12,18): 7 engine steps then one cycle into the output register
        got_q.delete();
        send(5, 12, 18, 0);
        wait_n(1, 100);
        if (got_q.size() >= 1) begin
            chk("t2_id", 64'(got_q[0].id), 64'd5);
            chk("t2_data", got_q[0].data, 64'd6);
            chk("t2_err", 64'(got_q[0].err), 64'd0);
            chk("t2_latency", 64'(got_q[0].lat), 64'd8);
        end

        // bad func_id
        got_q.delete();
        send(7, 3, 3, 1);
        wait_n(1, 20);
        if (got_q.size() >= 1) begin
            chk("t5_err", 64'(got_q[0].err), 64'd1);
            chk("t5_err_id", 64'(got_q[0].eid), 64'd1);
            chk("t5_data", got_q[0].data, 64'd0);
            chk("t5_latency_le3", 64'(got_q[0].lat <= 3), 64'd1);
        end

        // zero operands
        got_q.delete();
        send(8, 0, 0, 0);
        wait_n(1, 20);
        if (got_q.size() >= 1) begin
            chk("t6_zz_err", 64'(got_q[0].err), ZEN ? 64'd1 : 64'd0);
            chk("t6_zz_err_id", 64'(got_q[0].eid), ZEN ? 64'd2 : 64'd0);
            chk("t6_zz_data", got_q[0].data, 64'd0);
        end
        got_q.delete();
        send(9, 9, 0, 0);
        wait_n(1, 20);
        if (got_q.size() >= 1) begin
            chk("t6_b0_data", got_q[0].data, 64'd9);
            chk("t6_b0_err", 64'(got_q[0].err), 64'd0);
            chk("t6_b0_latency", 64'(got_q[0].lat), 64'd2);
        end
        got_q.delete();
        send(6, 0, 21, 0);
        wait_n(1, 20);
        if (got_q.size() >= 1) chk("t6_a0_data", got_q[0].data, 64'd21);

        // four back-to-back requests fill the pool; short ones finish first
        got_q.delete();
        send(1, 1, 1000, 0);
        send(2, 6, 9, 0);
        send(3, 7, 7, 0);
        send(4, 8, 4, 0);
        @(negedge clk);
        chk("t3_req_ready_full", {63'd0, req_ready}, 64'd0);
        sync();
        wait_n(4, 1500);
        if (got_q.size() >= 4) begin
            chk("t3_order0", 64'(got_q[0].id), 64'd3);
            chk("t3_order1", 64'(got_q[1].id), 64'd4);
            chk("t3_order2", 64'(got_q[2].id), 64'd2);
            chk("t3_order3", 64'(got_q[3].id), 64'd1);
            chk("t3_data0", got_q[0].data, 64'd7);
            chk("t3_data1", got_q[1].data, 64'd4);
            chk("t3_data2", got_q[2].data, 64'd3);
            chk("t3_data3", got_q[3].data, 64'd1);
        end

        // stall: id10 sits in the response register, ids 11/12 done behind it;
        // id13 lands on engine 0 after it frees. Round-robin from after engine 0
        // must serve 11, 12 before 13.
        got_q.delete();
        resp_ready = 1'b0;
        send(10, 5, 0, 0);
        send(11, 6, 0, 0);
        send(12, 7, 0, 0);
        repeat (20) sync();
        send(13, 8, 0, 0);
        repeat (3) sync();
        @(negedge clk);
        chk("t4_held_valid", {63'd0, resp_valid}, 64'd1);
        chk("t4_held_id", {56'd0, resp_id}, 64'd10);
        sync();
        resp_ready = 1'b1;
        wait_n(4, 50);
        if (got_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_order", 64'(got_q[i].id), 64'(10 + i));
                chk("t4_data", got_q[i].data, 64'(5 + i));
                chk("t4_back_to_back", 64'(got_q[i].cyc - got_q[0].cyc), 64'(i));
            end
        end

        // reset in the middle of three long computations
        got_q.delete();
        send(20, 1, 1000, 0);
        send(21, 1, 900, 0);
        send(22, 1, 800, 0);
        repeat (50) sync();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("t1_rst_req_ready", {63'd0, req_ready}, 64'd1);
        sync();
        rst = 1'b1;
        repeat (1200) sync();
        chk("t1_no_stale", 64'(got_q.size()), 64'd0);

        // randomized traffic
        got_q.delete();
        fork
            begin
                for (int r = 0; r < 300; r++) begin
                    longint unsigned a, b;
                    int sel, f;
                    repeat ($urandom_range(0, 2)) sync();
                    sel = $urandom_range(0, 9);
                    case (sel)
                        0: begin a = 0; b = $urandom_range(0, 60); end
                        1: begin a = $urandom_range(0, 60); b = 0; end
                        2: begin b = $urandom_range(1, 1000); a = b * $urandom_range(1, 50); end
                        3: begin a = $urandom; b = a; end
                        default: begin a = $urandom_range(1, 60); b = $urandom_range(1, 60); end
                    endcase
                    f = ($urandom_range(0, 9) == 0) ? 1 : 0;
                    send(next_id, a, b, f);
                    next_id = (next_id + 1) % 256;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    resp_ready = ($urandom_range(0, 99) < 65);
                end
                resp_ready = 1'b1;
            end
        join
        for (int k = 0; k < 5000; k++) begin
            if (inflight == 0) break;
            sync();
        end
        chk("rand_no_lost_ids", 64'(inflight), 64'd0);
        chk("rand_resp_count", 64'(got_q.size()), 64'd300);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
